// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the asynchronous SRAM controller.
// No logic; widths and default timing live here so every file agrees.
// Timing defaults are the minimum-safe settings for the board SRAM.
package sram_pkg;

    localparam int ADDR_W_DEF   = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int RD_WAIT_DEF  = 2;
    localparam int WR_PULSE_DEF = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_SETUP = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_SETUP = 3'd3;
    localparam logic [2:0] ST_WR_PULSE = 3'd4;
    localparam logic [2:0] ST_WR_HOLD  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_RD_SETUP = ST_RD_SETUP,
        S_RD_WAIT  = ST_RD_WAIT,
        S_WR_SETUP = ST_WR_SETUP,
        S_WR_PULSE = ST_WR_PULSE,
        S_WR_HOLD  = ST_WR_HOLD,
        S_DONE     = ST_DONE
    } state_e;

    // Counter must hold the larger of the two wait lengths.
    function automatic int cnt_width(input int rd_wait, input int wr_pulse);
        return $clog2((rd_wait > wr_pulse) ? rd_wait : wr_pulse) + 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/ack bundle for the SRAM controller.
// Single outstanding transaction; requester holds req/we/addr/wdata until ack.
// No backpressure beyond busy: req is only looked at while the controller idles.
interface sram_ctrl_if #(
    parameter int ADDR_W = sram_pkg::ADDR_W_DEF,
    parameter int DATA_W = sram_pkg::DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy
    );

endinterface

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter with zero flag, timing the SRAM access and write pulse.
// Load takes effect on the next edge; zero_o reflects the registered count.
// Saturates at zero; no handshake.
module sram_wait_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Sequences an asynchronous SRAM for single-beat CPU reads and writes.
// Latency: read ack RD_WAIT+2 cycles after accept, write ack WR_PULSE+3.
// One transaction at a time; req is ignored while busy.
module sram_ctrl #(
    parameter int ADDR_W   = sram_pkg::ADDR_W_DEF,
    parameter int DATA_W   = sram_pkg::DATA_W_DEF,
    parameter int RD_WAIT  = sram_pkg::RD_WAIT_DEF,
    parameter int WR_PULSE = sram_pkg::WR_PULSE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [DATA_W-1:0] sram_dq_io,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o
);

    import sram_pkg::*;

    localparam int CNT_W = cnt_width(RD_WAIT, WR_PULSE);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ack_q, ack_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;

    sram_wait_cnt #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.addr;
                    wr_d    = bus.wdata;
                    state_d = bus.we ? S_WR_SETUP : S_RD_SETUP;
                end
            end
            S_RD_SETUP: begin
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(RD_WAIT - 1);
                state_d      = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (cnt_zero) begin
                    rdata_d = sram_dq_io;
                    state_d = S_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WR_SETUP: begin
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(WR_PULSE - 1);
                state_d      = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (cnt_zero) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Pin strobes are decoded from the next state and then registered,
        // so they line up with the state and never see req combinationally.
        ack_d   = (state_d == S_DONE);
        ce_n_d  = !(state_d inside {S_RD_SETUP, S_RD_WAIT, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
        oe_n_d  = !(state_d inside {S_RD_SETUP, S_RD_WAIT});
        we_n_d  = (state_d != S_WR_PULSE);
        dq_oe_d = (state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wr_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dq_oe_q <= dq_oe_d;
        end
    end

    assign sram_dq_io  = dq_oe_q ? wr_q : 'z;
    assign sram_addr_o = addr_q;
    assign sram_ce_n_o = ce_n_q;
    assign sram_oe_n_o = oe_n_q;
    assign sram_we_n_o = we_n_q;

    assign bus.rdata = rdata_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: async SRAM model, reference memory, ack scoreboard.
module tb_sram_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int RDW = 2;
    localparam int WRP = 2;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    wire  [DW-1:0] sram_dq;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n, sram_oe_n, sram_we_n;

    sram_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RD_WAIT  (RDW),
        .WR_PULSE (WRP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .sram_addr_o (sram_addr),
        .sram_dq_io  (sram_dq),
        .sram_ce_n_o (sram_ce_n),
        .sram_oe_n_o (sram_oe_n),
        .sram_we_n_o (sram_we_n)
    );

    // Asynchronous SRAM: drives dq while selected and output-enabled, latches on we_n rise.
    logic [DW-1:0] smem [256];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? smem[sram_addr] : 'z;
    always @(posedge sram_we_n) if (!sram_ce_n) smem[sram_addr] = sram_dq;

    logic [DW-1:0] ref_mem [256];
    bit            known   [256];
    logic [DW-1:0] last_rd;
    exp_t          sbq [$];
    exp_t          mon_e;
    int            tests = 0;
    int            fails = 0;
    int            viol  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (!sram_oe_n && !sram_we_n) viol++;
            if (bus.ack) begin
                if (sbq.size() == 0) begin
                    chk("ack_with_nothing_outstanding", sbq.size(), 1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("ack_rdata", bus.rdata, mon_e.d);
                    chk("ack_sram_addr", sram_addr, mon_e.a);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction and check its cycle-by-cycle pin profile.
    task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit keep_req, input bit after_b2b, input bit poke);
        int          waits;
        int          lat;
        logic [31:0] oe_m, we_m, dq_m, e_oe, e_we, e_dq;
        exp_t        e;
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        e.w = w;
        e.a = a;
        if (w) begin
            ref_mem[a] = d;
            known[a]   = 1'b1;
            e.d        = last_rd;
        end else begin
            last_rd = ref_mem[a];
            e.d     = ref_mem[a];
        end
        sbq.push_back(e);

        waits = 0;
        do begin
            @(posedge clk);
            #1;
            waits++;
        end while (!bus.busy && waits < 8);
        chk("accept_wait_edges", waits, after_b2b ? 2 : 1);

        lat  = 1;
        oe_m = '0;
        we_m = '0;
        dq_m = '0;
        while (1) begin
            oe_m[lat] = !sram_oe_n;
            we_m[lat] = !sram_we_n;
            dq_m[lat] = (sram_dq === d);
            if (poke && lat == 2) begin
                bus.addr = 8'hFF;
                bus.req  = 1'b0;
            end
            if (poke && lat == 3) begin
                bus.req = 1'b1;
                chk("busy_ignore_sram_addr", sram_addr, a);
            end
            if (bus.ack || lat >= 16) break;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!keep_req) bus.req = 1'b0;

        e_oe = '0;
        e_we = '0;
        e_dq = '0;
        if (w) begin
            chk("write_ack_latency", lat, WRP + 3);
            for (int i = 2; i <= WRP + 1; i++) e_we[i] = 1'b1;
            for (int i = 1; i <= WRP + 2; i++) e_dq[i] = 1'b1;
            chk("write_dq_drive_cycles", dq_m, e_dq);
        end else begin
            chk("read_ack_latency", lat, RDW + 2);
            for (int i = 1; i <= RDW + 1; i++) e_oe[i] = 1'b1;
        end
        chk("oe_n_low_cycles", oe_m, e_oe);
        chk("we_n_low_cycles", we_m, e_we);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            kr;
        bit            b2b_prev;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        last_rd   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            smem[i]    = 8'($urandom);
            ref_mem[i] = smem[i];
            known[i]   = 1'b1;
        end
        smem[8'h3C]    = 8'hA5;
        ref_mem[8'h3C] = 8'hA5;

        chk("reset_ce_n", sram_ce_n, 1);
        chk("reset_oe_n", sram_oe_n, 1);
        chk("reset_we_n", sram_we_n, 1);
        chk("reset_ack", bus.ack, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rdata", bus.rdata, 0);
        chk("reset_sram_addr", sram_addr, 0);

        txn(1'b0, 8'h3C, 8'h11, 1'b0, 1'b0, 1'b0);
        idle();
        txn(1'b1, 8'h81, 8'h5A, 1'b1, 1'b0, 1'b0);
        txn(1'b0, 8'h81, 8'h22, 1'b0, 1'b1, 1'b0);
        idle();
        txn(1'b0, 8'h3C, 8'h33, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a cycle while rdata holds 0xA5.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rdata", bus.rdata, 0);
        chk("async_reset_ce_n", sram_ce_n, 1);
        chk("async_reset_oe_n", sram_oe_n, 1);
        chk("async_reset_we_n", sram_we_n, 1);
        chk("async_reset_busy", bus.busy, 0);
        chk("async_reset_sram_addr", sram_addr, 0);
        last_rd = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        b2b_prev = 1'b0;
        for (int k = 0; k < 40; k++) begin
            w = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            d = 8'($urandom);
            if (d == '0) d = 8'h01;
            if (!w && !known[a]) w = 1'b1;
            kr = (k < 39) && ($urandom_range(0, 2) == 0);
            if (!b2b_prev) idle();
            txn(w, a, d, kr, b2b_prev, 1'b0);
            b2b_prev = kr;
        end

        // Reset during the write pulse: strobes and bus release at once, no ack follows.
        idle();
        a = 8'h5E;
        d = 8'hC3;
        known[a]    = 1'b0;
        known[0]    = 1'b0;
        bus.req     = 1'b1;
        bus.we      = 1'b1;
        bus.addr    = a;
        bus.wdata   = d;
        repeat (2) idle();
        chk("midwrite_we_n_low_before_reset", sram_we_n, 0);
        #2;
        rst_n   = 1'b0;
        bus.req = 1'b0;
        #1;
        chk("midwrite_reset_we_n", sram_we_n, 1);
        chk("midwrite_reset_ce_n", sram_ce_n, 1);
        chk("midwrite_reset_dq_released", (sram_dq === d), 0);
        chk("midwrite_reset_busy", bus.busy, 0);
        chk("midwrite_reset_ack", bus.ack, 0);
        last_rd = '0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (6) idle();
        chk("after_reset_idle_busy", bus.busy, 0);
        txn(1'b0, 8'h3C, 8'h44, 1'b0, 1'b0, 1'b0);
        repeat (3) idle();

        chk("scoreboard_drained", sbq.size(), 0);
        chk("oe_we_overlap_cycles", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
